// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and acknowledge in, byte and sticky status flags out.
// The master modport is the line/consumer side, the slave modport is the receiver.
interface uart_rx_if;
  typedef logic [7:0] data_t;

  logic  rx;
  logic  clear_interrupt;
  data_t uart_data;
  logic  rx_interrupt;
  logic  framing_error;
  logic  overrun;
  logic  parity_error;

  modport master (
    output rx, clear_interrupt,
    input  uart_data, rx_interrupt, framing_error, overrun, parity_error
  );

  modport slave (
    input  rx, clear_interrupt,
    output uart_data, rx_interrupt, framing_error, overrun, parity_error
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling 8N1 receiver with sticky byte/error flags; UART_RX_PARITY_EN adds an even parity bit.
// Byte and flags update the cycle after the stop sample; no backpressure, an unacknowledged byte is overwritten and flagged.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  typedef logic [7:0] data_t;

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  logic [1:0]    sync_q;
  logic          rx_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  data_t         shift_q, shift_d;
  data_t         data_q, data_d;
  logic          irq_q, irq_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          bit_end;
  logic          good_stb;
  logic          ferr_stb;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          perr_q, perr_d;
  logic          perr_stb;
`endif

  assign rx_s    = sync_q[1];
  assign bit_end = (cyc_q == CW'(CPB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      irq_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], bus.rx};
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      irq_q     <= irq_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    good_stb  = 1'b0;
    ferr_stb  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_stb  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        // A start bit that is already high again at mid-bit is line noise.
        if (cyc_q == CW'(HALF - 1)) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cyc_d     = '0;
          par_bad_d = rx_s ^ (^shift_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leaving mid-stop-bit lets the next start edge be caught without a gap.
        if (bit_end) begin
          cyc_d    = '0;
          state_d  = S_IDLE;
          ferr_stb = !rx_s;
`ifdef UART_RX_PARITY_EN
          good_stb = rx_s && !par_bad_q;
          perr_stb = par_bad_q;
`else
          good_stb = rx_s;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    irq_d  = irq_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
`ifdef UART_RX_PARITY_EN
    perr_d = perr_q;
`endif
    if (bus.clear_interrupt) begin
      irq_d  = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d = 1'b0;
`endif
    end
    // A clear in the same cycle means the previous byte was consumed, so no overrun.
    if (good_stb) begin
      data_d = shift_q;
      irq_d  = 1'b1;
      if (irq_q && !bus.clear_interrupt) ovr_d = 1'b1;
    end
    if (ferr_stb) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
    if (perr_stb) perr_d = 1'b1;
`endif
  end

  assign bus.uart_data     = data_q;
  assign bus.rx_interrupt  = irq_q;
  assign bus.framing_error = ferr_q;
  assign bus.overrun       = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error  = perr_q;
`else
  assign bus.parity_error  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level reference model checked every cycle, directed scenarios, then random frames and clears.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS    = PAR_EN ? 11 : 10;
  // Edges from the rx fall to the update edge: two synchronizer edges, START entry, half a bit, then the remaining bits.
  localparam int LAT      = 3 + CPB / 2 + (NBITS - 1) * CPB;
  localparam int STOP_OFS = LAT - (NBITS - 1) * CPB;

  typedef struct {
    int         comp;
    bit         good;
    bit         ferr;
    bit         perr;
    logic [7:0] d;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  bit         rnd_done = 1'b0;
  evt_t       q[$];
  logic [7:0] e_data = '0;
  logic       e_irq  = 1'b0;
  logic       e_ferr = 1'b0;
  logic       e_ovr  = 1'b0;
  logic       e_perr = 1'b0;

  uart_rx_if u_if ();

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each frame resolves at one known edge; clear and set rules applied per edge.
  always @(posedge clk) begin
    evt_t ev;
    bit   g, f, p;
    logic [7:0] d;
    cyc <= cyc + 1;
    if (rst) begin
      q.delete();
      e_data <= '0;
      e_irq  <= 1'b0;
      e_ferr <= 1'b0;
      e_ovr  <= 1'b0;
      e_perr <= 1'b0;
    end else begin
      g = 1'b0; f = 1'b0; p = 1'b0; d = e_data;
      if (q.size() > 0 && q[0].comp == cyc + 1) begin
        ev = q.pop_front();
        g = ev.good; f = ev.ferr; p = ev.perr; d = ev.d;
      end
      if (u_if.clear_interrupt) begin
        e_irq  <= g;
        e_ferr <= f;
        e_perr <= p;
        e_ovr  <= 1'b0;
      end else begin
        e_irq  <= e_irq | g;
        e_ferr <= e_ferr | f;
        e_perr <= e_perr | p;
        e_ovr  <= e_ovr | (g & e_irq);
      end
      if (g) e_data <= d;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("uart_data",     u_if.uart_data,            e_data);
      check("rx_interrupt",  8'(u_if.rx_interrupt),     8'(e_irq));
      check("framing_error", 8'(u_if.framing_error),    8'(e_ferr));
      check("overrun",       8'(u_if.overrun),          8'(e_ovr));
      check("parity_error",  8'(u_if.parity_error),     8'(e_perr));
    end
  end

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_ok,
                            input bit clr_stop, input bit probe, input int gap);
    evt_t ev;
    @(negedge clk);
    ev.comp = cyc + LAT;
    ev.d    = d;
    ev.ferr = !stop;
    ev.perr = PAR_EN && !par_ok;
    ev.good = stop && (par_ok || !PAR_EN);
    q.push_back(ev);
    u_if.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR_EN) begin
      u_if.rx = (^d) ^ !par_ok;
      repeat (CPB) @(negedge clk);
    end
    u_if.rx = stop;
    for (int j = 0; j < CPB; j++) begin
      if (clr_stop) u_if.clear_interrupt = (j == STOP_OFS - 1);
      if (probe && j == STOP_OFS - 1) check("irq_before_stop_edge", 8'(u_if.rx_interrupt), 8'd0);
      if (probe && j == STOP_OFS) begin
        check("irq_after_stop_edge",  8'(u_if.rx_interrupt), 8'd1);
        check("data_after_stop_edge", u_if.uart_data, d);
      end
      @(negedge clk);
    end
    u_if.rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_clear();
    u_if.clear_interrupt = 1'b1;
    @(negedge clk);
    u_if.clear_interrupt = 1'b0;
  endtask

  initial begin
    u_if.rx = 1'b1;
    u_if.clear_interrupt = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", u_if.uart_data, 8'h00);
    check("rst_irq",  8'(u_if.rx_interrupt),  8'd0);
    check("rst_ferr", 8'(u_if.framing_error), 8'd0);
    check("rst_ovr",  8'(u_if.overrun),       8'd0);
    check("rst_perr", 8'(u_if.parity_error),  8'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Good byte, held until acknowledged
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    repeat (200) @(negedge clk);
    check("a5_irq_held", 8'(u_if.rx_interrupt), 8'd1);
    pulse_clear();
    check("a5_irq_cleared", 8'(u_if.rx_interrupt), 8'd0);
    check("a5_data_kept", u_if.uart_data, 8'hA5);

    // Glitch rejected, then a valid byte
    u_if.rx = 1'b0;
    repeat (4) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_irq",  8'(u_if.rx_interrupt),  8'd0);
    check("glitch_ferr", 8'(u_if.framing_error), 8'd0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    check("after_glitch_data", u_if.uart_data, 8'h3C);
    pulse_clear();

    // Framing error keeps the previous byte
    send_frame(8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 20);
    check("ferr_flag", 8'(u_if.framing_error), 8'd1);
    check("ferr_irq",  8'(u_if.rx_interrupt),  8'd1);
    check("ferr_data", u_if.uart_data, 8'h11);
    pulse_clear();

    // Overrun, then set-wins with a clear on the stop-sample edge
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    send_frame(8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    check("ovr_data", u_if.uart_data, 8'h02);
    check("ovr_flag", 8'(u_if.overrun), 8'd1);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    send_frame(8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 3);
    check("setwin_irq",  8'(u_if.rx_interrupt), 8'd1);
    check("setwin_ovr",  8'(u_if.overrun),      8'd0);
    check("setwin_data", u_if.uart_data, 8'h02);
    pulse_clear();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    check("par_good_data", u_if.uart_data, 8'h07);
    check("par_good_perr", 8'(u_if.parity_error), 8'd0);
    pulse_clear();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    check("par_bad_perr", 8'(u_if.parity_error), 8'd1);
    check("par_bad_irq",  8'(u_if.rx_interrupt), 8'd0);
    pulse_clear();
`endif

    // Reset during data bit 4 of 0xFF
    send_frame(8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    u_if.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_data", u_if.uart_data, 8'h00);
    check("midrst_irq",  8'(u_if.rx_interrupt),  8'd0);
    check("midrst_ferr", 8'(u_if.framing_error), 8'd0);
    check("midrst_ovr",  8'(u_if.overrun),       8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    check("post_rst_data", u_if.uart_data, 8'h5A);
    check("post_rst_irq",  8'(u_if.rx_interrupt), 8'd1);

    // Random frames with random acknowledges
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          bit stop;
          stop = ($urandom % 8) != 0;
          send_frame(8'($urandom), stop, ($urandom % 6) != 0, 1'b0, 1'b0,
                     stop ? int'($urandom_range(0, 20)) : int'($urandom_range(16, 30)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          u_if.clear_interrupt = ($urandom % 24) == 0;
        end
        u_if.clear_interrupt = 1'b0;
      end
    join

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
